// File: rtl/controlador_es.sv
// controlador_es: device-side responder for the processor's IN and OUT
// instructions.
//  - IN  stalls the processor and waits for a debounced press of the confirm
//    button. It then returns the switches with a one-cycle valid pulse.
//  - OUT latches the register value and the process number into the display
//    registers in a single cycle, without stalling.
// Optional feature: define CONTROLADOR_ES_TIMEOUT_EN to bound the IN wait to
// TIMEOUT_CYCLES cycles. When the bound expires the IN completes with
// dado_in = 0 and erro_timeout is set until the next reset.
//
// Processor handshake:
//  - stall high means the processor must hold its current instruction.
//  - dado_in_valido is a one-cycle pulse, during which stall is low.
//  - dado_in is valid in that cycle, and the processor retires the IN on the
//    edge that ends the pulse.
//  - There is no back-pressure from the processor side.
module controlador_es #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TIMEOUT_CYCLES  = 500000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [31:0] processo_atual,
   input  logic [31:0] dado_out,
   input  logic [15:0] chaves,
   input  logic        botao,
   output logic [31:0] dado_in,
   output logic        dado_in_valido,
   output logic        stall,
   output logic [31:0] display_valor,
   output logic [3:0]  display_processo,
   output logic        ledesperando,
   output logic        erro_timeout
);

   localparam logic [5:0] OP_IN  = 6'b011101;
   localparam logic [5:0] OP_OUT = 6'b011110;

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      OCIOSO        = 2'd0,
      ESPERA_SOLTO  = 2'd1,
      ESPERA_APERTO = 2'd2,
      CONCLUI       = 2'd3
   } estado_t;

   estado_t         estado;
   logic            sinc_a;
   logic            sinc_b;
   logic            botao_db;
   logic [DB_W-1:0] cnt_db;
   logic            esperando;
   logic            timeout_dispara;

   // Only the upper process bits are dropped; the display shows 0..10.
   logic unused_processo;
   assign unused_processo = ^processo_atual[31:4];

   assign esperando = (estado == ESPERA_SOLTO) || (estado == ESPERA_APERTO);

   // Stall is combinational so the processor freezes in the same cycle that
   // the IN opcode appears. It is forced low while reset is held.
   assign stall = reset && (esperando || ((estado == OCIOSO) && (opcode == OP_IN)));

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc_a <= 1'b0;
         sinc_b <= 1'b0;
      end else begin
         sinc_a <= botao;
         sinc_b <= sinc_a;
      end
   end

   // Debouncer: the synchronized value must disagree with botao_db for
   // DEBOUNCE_CYCLES consecutive samples before botao_db follows it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         botao_db <= 1'b0;
         cnt_db   <= '0;
      end else if (sinc_b != botao_db) begin
         if (cnt_db == DB_MAX) begin
            botao_db <= sinc_b;
            cnt_db   <= '0;
         end else begin
            cnt_db <= cnt_db + 1'b1;
         end
      end else begin
         cnt_db <= '0;
      end
   end

`ifdef CONTROLADOR_ES_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_to;

   // A press in the same cycle as expiry wins; the operator did answer.
   assign timeout_dispara = esperando && (cnt_to == TO_MAX) &&
                            !((estado == ESPERA_APERTO) && botao_db);

   // Wait-time counter: held at zero outside the wait states, so it restarts
   // on every entry to ESPERA_SOLTO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_to <= '0;
      end else if (!esperando) begin
         cnt_to <= '0;
      end else if (cnt_to != TO_MAX) begin
         cnt_to <= cnt_to + 1'b1;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         erro_timeout <= 1'b0;
      end else if (timeout_dispara) begin
         erro_timeout <= 1'b1;
      end
   end
`else
   // Without the timeout, the IN wait lasts as long as the operator takes.
   logic unused_timeout;
   assign unused_timeout  = (TIMEOUT_CYCLES > 0);
   assign timeout_dispara = 1'b0;
   assign erro_timeout    = 1'b0;
`endif

   // Transaction FSM, with registered valid, wait LED, capture and display
   // registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado           <= OCIOSO;
         dado_in          <= '0;
         dado_in_valido   <= 1'b0;
         display_valor    <= '0;
         display_processo <= '0;
         ledesperando     <= 1'b0;
      end else begin
         dado_in_valido <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (opcode == OP_IN) begin
                  estado       <= ESPERA_SOLTO;
                  ledesperando <= 1'b1;
               end else if (opcode == OP_OUT) begin
                  display_valor    <= dado_out;
                  display_processo <= processo_atual[3:0];
               end
            end
            ESPERA_SOLTO: begin
               // A button still held from an earlier IN must be released first.
               if (timeout_dispara) begin
                  estado         <= CONCLUI;
                  dado_in        <= '0;
                  dado_in_valido <= 1'b1;
                  ledesperando   <= 1'b0;
               end else if (!botao_db) begin
                  estado <= ESPERA_APERTO;
               end
            end
            ESPERA_APERTO: begin
               if (botao_db) begin
                  estado         <= CONCLUI;
                  dado_in        <= {16'b0, chaves};
                  dado_in_valido <= 1'b1;
                  ledesperando   <= 1'b0;
               end else if (timeout_dispara) begin
                  estado         <= CONCLUI;
                  dado_in        <= '0;
                  dado_in_valido <= 1'b1;
                  ledesperando   <= 1'b0;
               end
            end
            CONCLUI: begin
               estado <= OCIOSO;
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase
      end
   end

endmodule
